collision_scheduler: RTL and testbench

//  Arbitrates the three ball-pair collision events (pairs 1-2, 1-3, 2-3) onto the single

---
 rtl/collision_scheduler.sv | 165 ++++++++++++++++
 tb/tb_collision_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scheduler.sv
// Round-robin scheduler for the three ball-pair collision events onto one velocity-update
// datapath. Samples detectors once per frame and applies a per-pair cooldown after each ack.
module collision_scheduler #(
  parameter int unsigned COOLDOWN_FRAMES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       hit_12,
  input  logic       hit_13,
  input  logic       hit_23,
  input  logic [2:0] dir_12,
  input  logic [2:0] dir_13,
  input  logic [2:0] dir_23,
  input  logic       upd_ack,
  output logic       upd_valid,
  output logic [1:0] upd_pair,
  output logic [2:0] upd_dir,
  output logic       sched_busy,
  output logic [7:0] ovr_cnt
);

  typedef enum logic [1:0] {StIdle, StArb, StIssue} state_e;

  state_e           state_q, state_d;
  logic [2:0]       pend_q, pend_d;
  logic [CNT_W-1:0] cool_q [3];
  logic [CNT_W-1:0] cool_d [3];
  logic [2:0]       dsave_q [3];
  logic [2:0]       dsave_d [3];
  logic [1:0]       last_grant_q, last_grant_d;
  logic [1:0]       pair_q, pair_d;
  logic [2:0]       dir_q, dir_d;
  logic             valid_q, valid_d;
  logic [7:0]       ovr_q, ovr_d;

  logic [2:0] hit;
  logic [2:0] dir_in [3];
  logic [2:0] sample_pend;
  logic [1:0] rr1, rr2, arb_grant;
  logic       ack_hs;

  assign hit       = {hit_23, hit_13, hit_12};
  assign dir_in[0] = dir_12;
  assign dir_in[1] = dir_13;
  assign dir_in[2] = dir_23;
  assign ack_hs    = (state_q == StIssue) && upd_ack;

  // Eligibility uses the cooldown value before this tick's decrement.
  always_comb begin
    sample_pend = '0;
    for (int i = 0; i < 3; i++) begin
      sample_pend[i] = hit[i] && (cool_q[i] == '0);
    end
  end

  // Search order is last_grant+1, last_grant+2, then last_grant itself (mod 3).
  always_comb begin
    rr1 = (last_grant_q == 2'd2) ? 2'd0 : last_grant_q + 2'd1;
    rr2 = (rr1 == 2'd2) ? 2'd0 : rr1 + 2'd1;
    if (pend_q[rr1]) begin
      arb_grant = rr1;
    end else if (pend_q[rr2]) begin
      arb_grant = rr2;
    end else begin
      arb_grant = last_grant_q;
    end
  end

  // Cooldowns tick down in every state; a reload on ack wins over the decrement.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cool_d[i] = cool_q[i];
      if (frame_tick && (cool_q[i] != '0)) begin
        cool_d[i] = cool_q[i] - 1'b1;
      end
      if (ack_hs && (pair_q == 2'(i))) begin
        cool_d[i] = CNT_W'(COOLDOWN_FRAMES);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    dsave_d      = dsave_q;
    last_grant_d = last_grant_q;
    pair_d       = pair_q;
    dir_d        = dir_q;
    valid_d      = valid_q;
    ovr_d        = ovr_q;

    if (frame_tick && (state_q != StIdle) && (ovr_q != 8'hff)) begin
      ovr_d = ovr_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          pend_d = sample_pend;
          for (int i = 0; i < 3; i++) begin
            dsave_d[i] = dir_in[i];
          end
          if (sample_pend != '0) begin
            state_d = StArb;
          end
        end
      end
      StArb: begin
        pair_d  = arb_grant;
        dir_d   = dsave_q[arb_grant];
        valid_d = 1'b1;
        state_d = StIssue;
      end
      StIssue: begin
        if (upd_ack) begin
          pend_d[pair_q] = 1'b0;
          last_grant_d   = pair_q;
          valid_d        = 1'b0;
          state_d        = ((pend_q & ~(3'b001 << pair_q)) != '0) ? StArb : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      pend_q       <= '0;
      last_grant_q <= 2'd2;
      pair_q       <= '0;
      dir_q        <= '0;
      valid_q      <= 1'b0;
      ovr_q        <= '0;
      for (int i = 0; i < 3; i++) begin
        cool_q[i]  <= '0;
        dsave_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      last_grant_q <= last_grant_d;
      pair_q       <= pair_d;
      dir_q        <= dir_d;
      valid_q      <= valid_d;
      ovr_q        <= ovr_d;
      for (int i = 0; i < 3; i++) begin
        cool_q[i]  <= cool_d[i];
        dsave_q[i] <= dsave_d[i];
      end
    end
  end

  assign upd_valid  = valid_q;
  assign upd_pair   = pair_q;
  assign upd_dir    = dir_q;
  assign sched_busy = (state_q != StIdle);
  assign ovr_cnt    = ovr_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench for collision_scheduler: a frame-level reference model queues expected
// grants; a negedge monitor compares every presented request and the status outputs.
module tb_collision_scheduler;

  localparam int Cool = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       hit_12 = 1'b0, hit_13 = 1'b0, hit_23 = 1'b0;
  logic [2:0] dir_12 = '0, dir_13 = '0, dir_23 = '0;
  logic       upd_ack = 1'b0;
  logic       upd_valid;
  logic [1:0] upd_pair;
  logic [2:0] upd_dir;
  logic       sched_busy;
  logic [7:0] ovr_cnt;

  collision_scheduler #(
    .COOLDOWN_FRAMES(Cool),
    .CNT_W          (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .hit_12    (hit_12),
    .hit_13    (hit_13),
    .hit_23    (hit_23),
    .dir_12    (dir_12),
    .dir_13    (dir_13),
    .dir_23    (dir_23),
    .upd_ack   (upd_ack),
    .upd_valid (upd_valid),
    .upd_pair  (upd_pair),
    .upd_dir   (upd_dir),
    .sched_busy(sched_busy),
    .ovr_cnt   (ovr_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  typedef struct {
    int pair;
    int dir;
  } exp_t;

  exp_t exp_q[$];   // scoreboard: requests the DUT must present, in order
  int   m_todo[$];  // model: pairs still owed a grant in the current frame batch
  int   m_cool[3];
  int   m_lg  = 2;
  int   m_ovr = 0;
  bit   m_arb = 1'b0;   // one arbitration cycle between sample/ack and the next request
  bit   m_valid = 1'b0;
  int   hs_cnt[3];

  bit   busy_pre, hs, sampled, new_arb;
  bit   elig[3];
  int   dsv[3];
  int   hv[3];
  int   g, p;

  // Frame-level reference model.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_todo.delete();
      exp_q.delete();
      for (int i = 0; i < 3; i++) m_cool[i] = 0;
      m_lg = 2; m_ovr = 0; m_arb = 1'b0; m_valid = 1'b0;
    end else begin
      hv[0] = hit_12; hv[1] = hit_13; hv[2] = hit_23;
      busy_pre = (m_todo.size() > 0);
      hs       = busy_pre && !m_arb && upd_ack;
      sampled  = 1'b0;
      new_arb  = 1'b0;
      if (frame_tick) begin
        if (busy_pre) begin
          m_ovr = (m_ovr >= 255) ? 255 : m_ovr + 1;
        end else begin
          dsv[0] = dir_12; dsv[1] = dir_13; dsv[2] = dir_23;
          for (int i = 0; i < 3; i++) begin
            elig[i] = (hv[i] != 0) && (m_cool[i] == 0);
            if (elig[i]) sampled = 1'b1;
          end
        end
        for (int i = 0; i < 3; i++) if (m_cool[i] > 0) m_cool[i]--;
      end
      if (hs) begin
        g         = m_todo.pop_front();
        m_cool[g] = Cool;
        m_lg      = g;
        new_arb   = (m_todo.size() > 0);
      end
      if (sampled) begin
        // One frame's batch is served in cyclic order starting after the last grant.
        for (int k = 1; k <= 3; k++) begin
          p = (m_lg + k) % 3;
          if (elig[p]) begin
            m_todo.push_back(p);
            exp_q.push_back('{pair: p, dir: dsv[p]});
          end
        end
        new_arb = 1'b1;
      end
      m_arb   = new_arb;
      m_valid = (m_todo.size() > 0) && !m_arb;
    end
  end

  // Monitor: compares outputs mid-cycle, pops the scoreboard on each completed handshake.
  always @(negedge clk) begin
    if (rst) begin
      check("upd_valid", int'(upd_valid), int'(m_valid));
      check("sched_busy", int'(sched_busy), (m_todo.size() > 0) ? 1 : 0);
      check("ovr_cnt", int'(ovr_cnt), m_ovr);
      if (upd_valid) begin
        check("req_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          check("upd_pair", int'(upd_pair), exp_q[0].pair);
          check("upd_dir", int'(upd_dir), exp_q[0].dir);
          if (upd_ack) begin
            if (upd_pair != 2'd3) hs_cnt[upd_pair]++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Inputs change 2 time units after a rising edge and hold for one cycle.
  task automatic drive(input bit t, input bit [2:0] h, input bit ack, input bit [8:0] d);
    frame_tick = t;
    {hit_23, hit_13, hit_12} = h;
    upd_ack = ack;
    {dir_23, dir_13, dir_12} = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_cycles(input int n, input bit ack);
    for (int i = 0; i < n; i++) drive(1'b0, 3'b000, ack, 9'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    frame_tick = 1'b0; upd_ack = 1'b0;
    {hit_23, hit_13, hit_12} = 3'b000;
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle_cycles(1, 1'b0);
  endtask

  int base;

  initial begin
    for (int i = 0; i < 3; i++) hs_cnt[i] = 0;
    do_reset();
    check("rst_valid", int'(upd_valid), 0);
    check("rst_pair", int'(upd_pair), 0);
    check("rst_dir", int'(upd_dir), 0);
    check("rst_busy", int'(sched_busy), 0);
    check("rst_ovr", int'(ovr_cnt), 0);

    // Single pair, latency and handshake.
    drive(1'b1, 3'b001, 1'b0, 9'b000_000_101);
    check("lat_arb_valid", int'(upd_valid), 0);
    drive(1'b0, 3'b000, 1'b0, 9'h0);
    check("lat_valid", int'(upd_valid), 1);
    check("lat_pair", int'(upd_pair), 0);
    check("lat_dir", int'(upd_dir), 5);
    drive(1'b0, 3'b000, 1'b1, 9'h0);
    check("ack_valid", int'(upd_valid), 0);
    check("ack_busy", int'(sched_busy), 0);

    // All pairs from reset, then again once cooldowns have expired.
    do_reset();
    drive(1'b1, 3'b111, 1'b0, 9'($urandom));
    idle_cycles(12, 1'b1);
    for (int f = 0; f < 5; f++) begin
      drive(1'b1, 3'b000, 1'b0, 9'h0);
      idle_cycles(3, 1'b1);
    end
    drive(1'b1, 3'b111, 1'b0, 9'($urandom));
    drive(1'b0, 3'b000, 1'b0, 9'h0);
    check("rr_restart_pair", int'(upd_pair), 0);
    idle_cycles(12, 1'b1);

    // Held hit on 1-3 with cooldown: grants only at frames 0 and 5.
    do_reset();
    base = hs_cnt[1];
    for (int f = 0; f < 6; f++) begin
      drive(1'b1, 3'b010, 1'b1, 9'($urandom));
      idle_cycles(5, 1'b1);
    end
    check("cooldown_grants", hs_cnt[1] - base, 2);

    // Ack withheld across frame ticks; overrun counter saturates.
    do_reset();
    drive(1'b1, 3'b111, 1'b0, 9'($urandom));
    idle_cycles(3, 1'b0);
    for (int f = 0; f < 3; f++) begin
      drive(1'b1, 3'b111, 1'b0, 9'($urandom));
      idle_cycles(1, 1'b0);
    end
    check("ovr_three", int'(ovr_cnt), 3);
    for (int f = 0; f < 297; f++) begin
      drive(1'b1, 3'($urandom), 1'b0, 9'($urandom));
      idle_cycles(1, 1'b0);
    end
    check("ovr_sat", int'(ovr_cnt), 255);
    drive(1'b1, 3'b000, 1'b1, 9'h0);  // tick and ack together
    idle_cycles(10, 1'b1);

    // Asynchronous reset mid-handshake.
    drive(1'b1, 3'b110, 1'b0, 9'($urandom));
    idle_cycles(3, 1'b0);
    rst = 1'b0;
    #1;
    check("async_valid", int'(upd_valid), 0);
    check("async_busy", int'(sched_busy), 0);
    check("async_ovr", int'(ovr_cnt), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle_cycles(1, 1'b0);
    drive(1'b1, 3'b111, 1'b0, 9'($urandom));
    drive(1'b0, 3'b000, 1'b0, 9'h0);
    check("post_rst_pair", int'(upd_pair), 0);
    idle_cycles(10, 1'b1);

    // Ack in idle, tick with no hits.
    idle_cycles(3, 1'b1);
    drive(1'b1, 3'b000, 1'b1, 9'($urandom));
    idle_cycles(2, 1'b0);
    check("nohit_busy", int'(sched_busy), 0);
    check("nohit_valid", int'(upd_valid), 0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      drive(($urandom_range(0, 4) == 0), 3'($urandom), ($urandom_range(0, 2) != 0),
            9'($urandom));
    end

    // Drain with a bounded wait.
    for (int c = 0; c < 60 && (exp_q.size() > 0 || m_todo.size() > 0); c++) begin
      idle_cycles(1, 1'b1);
    end
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
